mult_seq: RTL and testbench

- Multicycle 32x32 -> 64-bit multiplier for the MIPS MULT/MULTU path; it is the inverse-operation companion of the sequential unsigned divider.
- Uses the same start/busy/over handshake as the divider, so the HI/LO control logic drives both units identically.
- Radix-2 shift-add on operand magnitudes, then a one-cycle sign fix-up.

---
 rtl/mips_pkg.sv | 13 +
 rtl/abs32.sv | 17 +
 rtl/mult_seq.sv | 124 ++++++++++++
 tb/tb_mult_seq.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Constants shared by the multicycle HI/LO units (multiplier and divider).
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX
    } mul_state_e;

    localparam int unsigned MUL_ITER  = 32;
    localparam int unsigned MUL_CNT_W = 5;

endpackage

// File: rtl/abs32.sv
// Two's-complement magnitude with sign-out; passes the value through when unsigned.
module abs32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             is_signed,
    output logic [WIDTH-1:0] mag,
    output logic             sign
);

    // The most negative value maps to itself, which is correct read as unsigned.
    always_comb begin
        sign = is_signed & value[WIDTH-1];
        mag  = sign ? (~value + 1'b1) : value;
    end

endmodule

// File: rtl/mult_seq.sv
// Sequential radix-2 shift-add multiplier on magnitudes with a final sign fix-up cycle.
module mult_seq
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    input  logic             start,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             over
);

    mul_state_e             state_q, state_d;
    logic [MUL_CNT_W-1:0]   count_q, count_d;
    logic [WIDTH:0]         acc_q, acc_d;
    logic [WIDTH-1:0]       mq_q, mq_d;
    logic [WIDTH-1:0]       mag_a_q, mag_a_d;
    logic                   neg_q, neg_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic                   over_q, over_d;

    logic [WIDTH-1:0]       in_mag_a, in_mag_b;
    logic                   in_sign_a, in_sign_b;
    logic [WIDTH:0]         sum;
    logic [2*WIDTH-1:0]     product;
    logic [2*WIDTH-1:0]     fixed;

    abs32 #(.WIDTH(WIDTH)) u_abs_a (
        .value     (a),
        .is_signed (is_signed),
        .mag       (in_mag_a),
        .sign      (in_sign_a)
    );

    abs32 #(.WIDTH(WIDTH)) u_abs_b (
        .value     (b),
        .is_signed (is_signed),
        .mag       (in_mag_b),
        .sign      (in_sign_b)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        mag_a_d = mag_a_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        over_d  = over_q;

        // acc_q[WIDTH] is always zero after a shift, so adding it is harmless.
        sum     = acc_q + {1'b0, (mq_q[0] ? mag_a_q : '0)};
        product = {acc_q[WIDTH-1:0], mq_q};
        fixed   = neg_q ? (~product + 1'b1) : product;

        if (start) begin
            mag_a_d = in_mag_a;
            mq_d    = in_mag_b;
            neg_d   = in_sign_a ^ in_sign_b;
            acc_d   = '0;
            count_d = '0;
            over_d  = 1'b0;
            state_d = ST_RUN;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    acc_d   = {1'b0, sum[WIDTH:1]};
                    mq_d    = {sum[0], mq_q[WIDTH-1:1]};
                    count_d = count_q + 1'b1;
                    if (count_q == MUL_CNT_W'(MUL_ITER - 1)) begin
                        state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi_d    = fixed[2*WIDTH-1:WIDTH];
                    lo_d    = fixed[WIDTH-1:0];
                    over_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            mag_a_q <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            mag_a_q <= mag_a_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            over_q  <= over_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != ST_IDLE);
    assign over = over_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed and randomised checks of mult_seq latency, handshake and products.
module tb_mult_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        is_signed = 1'b0;
    logic        start = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, over;

    int tests = 0;
    int fails = 0;

    mult_seq #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .start     (start),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .over      (over)
    );

    always #5 clock = ~clock;

    // Drive a one-cycle start pulse and wait for E33; inputs change on negedges.
    task automatic run_op(input logic [31:0] va, input logic [31:0] vb, input logic sg);
        @(negedge clock);
        a = va; b = vb; is_signed = sg; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (33) @(negedge clock);
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({hi, lo, busy, over} !== 66'd0) begin
            fails++;
            $display("FAIL reset_state: hi=%h lo=%h busy=%b over=%b, required all 0", hi, lo, busy, over);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_unsigned_max();
        @(negedge clock);
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; is_signed = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        tests++;
        if (busy !== 1'b1 || over !== 1'b0) begin
            fails++;
            $display("FAIL umax_after_e0: busy=%b over=%b, required busy=1 over=0", busy, over);
        end
        repeat (32) @(negedge clock);
        tests++;
        if (busy !== 1'b1 || over !== 1'b0) begin
            fails++;
            $display("FAIL umax_after_e32: busy=%b over=%b, required busy=1 over=0", busy, over);
        end
        @(negedge clock);
        tests++;
        if (busy !== 1'b0 || over !== 1'b1) begin
            fails++;
            $display("FAIL umax_after_e33: busy=%b over=%b, required busy=0 over=1", busy, over);
        end
        tests++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            fails++;
            $display("FAIL umax_product: got %h_%h, required fffffffe_00000001", hi, lo);
        end
    endtask

    task automatic test_signed_mixed();
        run_op(32'hFFFF_FFFD, 32'h0000_0005, 1'b1);
        tests++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
            fails++;
            $display("FAIL signed_m3x5: got %h_%h, required ffffffff_fffffff1", hi, lo);
        end
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        tests++;
        if (hi !== 32'h0 || lo !== 32'h1) begin
            fails++;
            $display("FAIL signed_m1xm1: got %h_%h, required 00000000_00000001", hi, lo);
        end
    endtask

    task automatic test_signed_corner();
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        tests++;
        if (hi !== 32'h4000_0000 || lo !== 32'h0) begin
            fails++;
            $display("FAIL signed_min_sq: got %h_%h, required 40000000_00000000", hi, lo);
        end
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0);
        tests++;
        if (hi !== 32'h4000_0000 || lo !== 32'h0) begin
            fails++;
            $display("FAIL unsigned_min_sq: got %h_%h, required 40000000_00000000", hi, lo);
        end
        run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        tests++;
        if (hi !== 32'hC000_0000 || lo !== 32'h8000_0000) begin
            fails++;
            $display("FAIL signed_min_x_max: got %h_%h, required c0000000_80000000", hi, lo);
        end
    endtask

    task automatic test_restart();
        logic busy_ok;
        logic over_seen;
        logic [31:0] old_hi, old_lo;
        logic [31:0] mid_hi, mid_lo;
        busy_ok = 1'b1;
        over_seen = 1'b0;
        old_hi = hi;
        old_lo = lo;
        @(negedge clock);
        a = 32'd7; b = 32'd6; is_signed = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) begin
            @(negedge clock);
            busy_ok &= busy;
            over_seen |= over;
        end
        a = 32'h1234_5678; b = 32'h0000_0010; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        mid_hi = hi;
        mid_lo = lo;
        repeat (32) begin
            busy_ok &= busy;
            over_seen |= over;
            @(negedge clock);
        end
        busy_ok &= busy;
        over_seen |= over;
        tests++;
        if (mid_hi !== old_hi || mid_lo !== old_lo) begin
            fails++;
            $display("FAIL restart_hold_old: got %h_%h, required %h_%h", mid_hi, mid_lo, old_hi, old_lo);
        end
        tests++;
        if (busy_ok !== 1'b1 || over_seen !== 1'b0) begin
            fails++;
            $display("FAIL restart_handshake: busy_continuous=%b over_seen=%b, required 1/0", busy_ok, over_seen);
        end
        @(negedge clock);
        tests++;
        if (hi !== 32'h0000_0001 || lo !== 32'h2345_6780 || over !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL restart_result: got %h_%h over=%b busy=%b, required 00000001_23456780 over=1 busy=0",
                     hi, lo, over, busy);
        end
    endtask

    task automatic test_reset_mid_op();
        logic bad;
        bad = 1'b0;
        @(negedge clock);
        a = 32'hDEAD_BEEF; b = 32'h0000_1234; is_signed = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (14) @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if ({hi, lo, busy, over} !== 66'd0) begin
            fails++;
            $display("FAIL reset_mid_op: hi=%h lo=%h busy=%b over=%b, required all 0", hi, lo, busy, over);
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (40) begin
            @(negedge clock);
            if ({hi, lo, busy, over} !== 66'd0) bad = 1'b1;
        end
        tests++;
        if (bad !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: outputs left 0 during idle, now hi=%h lo=%h busy=%b over=%b",
                     hi, lo, busy, over);
        end
    endtask

    task automatic test_hold();
        logic bad;
        bad = 1'b0;
        run_op(32'h0001_0003, 32'h0002_0005, 1'b0);
        tests++;
        if (hi !== 32'h0000_0002 || lo !== 32'h000B_000F) begin
            fails++;
            $display("FAIL hold_setup: got %h_%h, required 00000002_000b000f", hi, lo);
        end
        repeat (50) begin
            @(negedge clock);
            a = $urandom; b = $urandom; is_signed = 1'($urandom);
            @(posedge clock);
            #1;
            if (hi !== 32'h0000_0002 || lo !== 32'h000B_000F || over !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        tests++;
        if (bad !== 1'b0) begin
            fails++;
            $display("FAIL hold_idle: got %h_%h over=%b busy=%b, required 00000002_000b000f over=1 busy=0",
                     hi, lo, over, busy);
        end
    endtask

    task automatic test_random();
        logic [31:0] ra, rb;
        logic        rs;
        logic [63:0] expected;
        longint      sa, sb;
        longint unsigned ua, ub;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            if (rs) begin
                sa = longint'($signed(ra));
                sb = longint'($signed(rb));
                expected = 64'(sa * sb);
            end else begin
                ua = 64'(ra);
                ub = 64'(rb);
                expected = ua * ub;
            end
            run_op(ra, rb, rs);
            tests++;
            if ({hi, lo} !== expected || over !== 1'b1) begin
                fails++;
                $display("FAIL random_%0d: a=%h b=%h s=%b got %h_%h over=%b, required %h over=1",
                         i, ra, rb, rs, hi, lo, over, expected);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed_mixed();
        test_signed_corner();
        test_restart();
        test_reset_mid_op();
        test_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
